// File: rtl/fetch.sv
// Instruction fetch: one outstanding bus request, one-entry hold buffer,
// redirect squashing with a drop state for in-flight requests.
module fetch #(
  parameter logic [63:0] PCINIT = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr_raw,
  output logic [63:0] instr_pc
);

  typedef enum logic [1:0] {
    BUSY = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] drop_q, drop_d;
  logic        vld_q, vld_d;
  logic [31:0] raw_q, raw_d;
  logic [63:0] opc_q, opc_d;
  logic [31:0] braw_q, braw_d;
  logic [63:0] bpc_q, bpc_d;

  logic        free;
  logic [63:0] tgt;
  logic        unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign free       = !vld_q || !stall;
  assign tgt        = {redirect_pc[63:2], 2'b00};

  // The buffer is only meaningful in HOLD, so leaving HOLD invalidates it.
  assign ireq_valid  = !reset && (state_q != HOLD);
  assign ireq_addr   = (state_q == DROP) ? drop_q : pc_q;
  assign instr_valid = vld_q;
  assign instr_raw   = raw_q;
  assign instr_pc    = opc_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    vld_d   = vld_q;
    raw_d   = raw_q;
    opc_d   = opc_q;
    braw_d  = braw_q;
    bpc_d   = bpc_q;
    if (redirect_valid) begin
      vld_d = 1'b0;
      pc_d  = tgt;
      unique case (state_q)
        BUSY: begin
          if (!iresp_data_ok) begin
            drop_d  = pc_q;
            state_d = DROP;
          end
        end
        HOLD: state_d = BUSY;
        DROP: begin
          if (iresp_data_ok) state_d = BUSY;
        end
        default: state_d = BUSY;
      endcase
    end else begin
      if (free) vld_d = 1'b0;
      unique case (state_q)
        BUSY: begin
          if (iresp_data_ok) begin
            pc_d = pc_q + 64'd4;
            if (free) begin
              vld_d = 1'b1;
              raw_d = iresp_data;
              opc_d = pc_q;
            end else begin
              braw_d  = iresp_data;
              bpc_d   = pc_q;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (free) begin
            vld_d   = 1'b1;
            raw_d   = braw_q;
            opc_d   = bpc_q;
            state_d = BUSY;
          end
        end
        DROP: begin
          if (iresp_data_ok) state_d = BUSY;
        end
        default: state_d = BUSY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BUSY;
      pc_q    <= PCINIT;
      drop_q  <= 64'd0;
      vld_q   <= 1'b0;
      raw_q   <= 32'd0;
      opc_q   <= 64'd0;
      braw_q  <= 32'd0;
      bpc_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      vld_q   <= vld_d;
      raw_q   <= raw_d;
      opc_q   <= opc_d;
      braw_q  <= braw_d;
      bpc_q   <= bpc_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: streaming, stall/hold, redirect squash,
// reset mid-flight and pc wrap.
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr_raw;
  logic [63:0] instr_pc;

  int checks = 0;
  int errors = 0;

  fetch dut (
    .clk           (clk),
    .reset         (reset),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .iresp_data_ok (iresp_data_ok),
    .iresp_data    (iresp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .instr_raw     (instr_raw),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic ok, input logic [31:0] d,
                     input logic st);
    iresp_data_ok = ok;
    iresp_data    = d;
    stall         = st;
  endtask

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    drv(1'b0, 32'd0, 1'b0);
    tick();
    tick();
    chk("rst_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_instr_pc", instr_pc, 64'd0);
    chk("rst_instr_raw", {32'd0, instr_raw}, 64'd0);

    // streaming
    reset = 1'b0;
    #1;
    chk("rel_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("rel_ireq_addr", ireq_addr, 64'h8000_0000);
    drv(1'b1, 32'h0000_0013, 1'b0);
    tick();
    chk("s0_valid", {63'd0, instr_valid}, 64'd1);
    chk("s0_pc", instr_pc, 64'h8000_0000);
    chk("s0_raw", {32'd0, instr_raw}, 64'h13);
    tick();
    chk("s1_valid", {63'd0, instr_valid}, 64'd1);
    chk("s1_pc", instr_pc, 64'h8000_0004);
    tick();
    chk("s2_valid", {63'd0, instr_valid}, 64'd1);
    chk("s2_pc", instr_pc, 64'h8000_0008);
    chk("s2_addr", ireq_addr, 64'h8000_000C);

    // stall into HOLD
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv(1'b1, 32'h0000_0013, 1'b0);
    tick();
    drv(1'b1, 32'h0010_0093, 1'b1);
    tick();
    drv(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("hold_ireq_valid", {63'd0, ireq_valid}, 64'd0);
      chk("hold_pc", instr_pc, 64'h8000_0000);
      chk("hold_valid", {63'd0, instr_valid}, 64'd1);
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    chk("unhold_pc", instr_pc, 64'h8000_0004);
    chk("unhold_raw", {32'd0, instr_raw}, 64'h0010_0093);
    chk("unhold_valid", {63'd0, instr_valid}, 64'd1);
    chk("unhold_addr", ireq_addr, 64'h8000_0008);
    chk("unhold_ireq_valid", {63'd0, ireq_valid}, 64'd1);

    // redirect with request outstanding, no data_ok
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    drv(1'b0, 32'h0, 1'b0);
    tick();
    redirect_valid = 1'b0;
    chk("drop_valid", {63'd0, instr_valid}, 64'd0);
    chk("drop_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("drop_addr0", ireq_addr, 64'h8000_0008);
    tick();
    chk("drop_addr1", ireq_addr, 64'h8000_0008);
    drv(1'b1, 32'hDEAD_BEEF, 1'b0);
    tick();
    chk("drop_done_valid", {63'd0, instr_valid}, 64'd0);
    chk("drop_done_addr", ireq_addr, 64'h8000_0100);
    drv(1'b1, 32'h1111_1111, 1'b0);
    tick();
    chk("tgt_pc", instr_pc, 64'h8000_0100);
    chk("tgt_raw", {32'd0, instr_raw}, 64'h1111_1111);

    // redirect coincident with data_ok, unaligned target
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0203;
    drv(1'b1, 32'hBAD0_BAD0, 1'b0);
    tick();
    redirect_valid = 1'b0;
    chk("rdok_valid", {63'd0, instr_valid}, 64'd0);
    chk("rdok_addr", ireq_addr, 64'h8000_0200);
    drv(1'b1, 32'h2222_2222, 1'b0);
    tick();
    chk("rdok_pc", instr_pc, 64'h8000_0200);
    chk("rdok_raw", {32'd0, instr_raw}, 64'h2222_2222);

    // redirect in HOLD
    drv(1'b1, 32'h3333_3333, 1'b1);
    tick();
    chk("h2_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0300;
    drv(1'b0, 32'h0, 1'b1);
    tick();
    redirect_valid = 1'b0;
    chk("rh_valid", {63'd0, instr_valid}, 64'd0);
    chk("rh_ireq_valid", {63'd0, ireq_valid}, 64'd1);
    chk("rh_addr", ireq_addr, 64'h8000_0300);
    drv(1'b1, 32'h4444_4444, 1'b0);
    tick();
    chk("rh_pc", instr_pc, 64'h8000_0300);
    chk("rh_raw", {32'd0, instr_raw}, 64'h4444_4444);

    // reset mid-request
    drv(1'b0, 32'h0, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("rmr_ireq_comb", {63'd0, ireq_valid}, 64'd0);
    tick();
    chk("rmr_valid", {63'd0, instr_valid}, 64'd0);
    chk("rmr_pc", instr_pc, 64'd0);
    reset = 1'b0;
    #1;
    chk("rmr_addr", ireq_addr, 64'h8000_0000);
    chk("rmr_ireq_valid", {63'd0, ireq_valid}, 64'd1);

    // reset mid-HOLD
    drv(1'b1, 32'h5555_5555, 1'b0);
    tick();
    drv(1'b1, 32'h6666_6666, 1'b1);
    tick();
    reset = 1'b1;
    drv(1'b0, 32'h0, 1'b0);
    tick();
    chk("rmh_ireq_valid", {63'd0, ireq_valid}, 64'd0);
    chk("rmh_valid", {63'd0, instr_valid}, 64'd0);
    reset = 1'b0;
    #1;
    chk("rmh_addr", ireq_addr, 64'h8000_0000);
    tick();
    chk("rmh_nobuf_valid", {63'd0, instr_valid}, 64'd0);
    drv(1'b1, 32'h7777_7777, 1'b0);
    tick();
    chk("rmh_pc", instr_pc, 64'h8000_0000);
    chk("rmh_raw", {32'd0, instr_raw}, 64'h7777_7777);

    // redirect in DROP, then redirect with DROP data_ok
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0400;
    drv(1'b0, 32'h0, 1'b0);
    tick();
    redirect_pc = 64'h8000_0500;
    tick();
    chk("dd_addr", ireq_addr, 64'h8000_0004);
    redirect_pc = 64'h8000_0600;
    drv(1'b1, 32'hBAD1_BAD1, 1'b0);
    tick();
    redirect_valid = 1'b0;
    chk("dd_valid", {63'd0, instr_valid}, 64'd0);
    chk("dd_new_addr", ireq_addr, 64'h8000_0600);

    // pc wrap
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    drv(1'b1, 32'h0, 1'b0);
    tick();
    redirect_valid = 1'b0;
    chk("wrap_addr0", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drv(1'b1, 32'h8888_8888, 1'b0);
    tick();
    chk("wrap_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_addr1", ireq_addr, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter PCINIT, default 64'h8000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ireq_valid  output  1  instruction-bus read request.
REQ-005 ireq_addr  output  64  request address, word aligned.
REQ-006 iresp_data_ok  input  1  response strobe; completes the outstanding request.
REQ-007 iresp_data  input  32  instruction word, valid when iresp_data_ok=1.
REQ-008 redirect_valid  input  1  control-flow redirect from execute.
REQ-009 redirect_pc  input  64  redirect target; bits [1:0] ignored (treated as 0).
REQ-010 stall  input  1  decode cannot accept this cycle.
REQ-011 instr_valid  output  1  instruction presented to decode.
REQ-012 instr_raw  output  32  raw instruction word to decoder.
REQ-013 instr_pc  output  64  PC of instr_raw.

Function
REQ-014 Registered state: pc, drop_addr, FSM state, output slot (instr_valid/raw/pc), one-entry hold buffer (buf_raw/buf_pc).
REQ-015 FSM states BUSY, HOLD, DROP; encoded 2 bits.
REQ-016 Slot "free" in a cycle = !instr_valid || !stall; instr accepted by decode when instr_valid && !stall.
REQ-017 BUSY: ireq_valid=1, ireq_addr=pc.
REQ-018 BUSY, data_ok, no redirect, slot free: output slot <= {1, iresp_data, pc} next edge; pc <= pc+4; stay BUSY.
REQ-019 BUSY, data_ok, no redirect, slot not free: buffer <= {iresp_data, pc}; pc <= pc+4; -> HOLD.
REQ-020 HOLD: ireq_valid=0; when slot free, output slot <= buffer, -> BUSY.
REQ-021 DROP: ireq_valid=1, ireq_addr=drop_addr (squashed request held until completed); on data_ok response discarded, -> BUSY.
REQ-022 Bus rule: once ireq_valid asserted, ireq_valid and ireq_addr stay constant until the data_ok cycle, in all states.
REQ-023 Redirect has priority over all other events; in its cycle: instr_valid <= 0, buffer invalidated, pc <= {redirect_pc[63:2],2'b00}.
REQ-024 Redirect in BUSY without data_ok: drop_addr <= pc, -> DROP.
REQ-025 Redirect in BUSY with data_ok: response discarded, -> BUSY (next request at new pc).
REQ-026 Redirect in HOLD: -> BUSY; redirect in DROP: pc updated, stay DROP, drop_addr unchanged.
REQ-027 Redirect and DROP-state data_ok same cycle: response discarded, -> BUSY with new pc.
REQ-028 pc increment modulo 2^64; 64'hFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
REQ-029 Output slot holds value (no change) while instr_valid && stall && no redirect.
REQ-030 Fetch-to-decode latency: instr_valid rises on the edge after the data_ok cycle.
REQ-031 Instructions reach decode in program order, none duplicated, none lost except those squashed by redirect.

Reset
REQ-032 While reset=1: ireq_valid=0 (combinationally gated), instr_valid <= 0, buffer invalidated.
REQ-033 On reset: pc <= PCINIT, drop_addr <= 0, instr_raw <= 0, instr_pc <= 0, state <= BUSY.
REQ-034 Reset asserted with request outstanding abandons it; bus side tolerates this; no drop issued.
REQ-035 First cycle after reset release: ireq_valid=1, ireq_addr=PCINIT.

Verification
REQ-036 Reset release, data_ok every cycle, data 32'h0000_0013, stall=0 -> instr_pc 8000_0000, 8000_0004, 8000_0008 on consecutive cycles, instr_valid continuous.
REQ-037 stall=1 held 3 cycles with data_ok at 8000_0004 -> state HOLD, ireq_valid=0, instr_pc stays 8000_0000; stall drop -> 8000_0000 accepted, then 8000_0004 next cycle.
REQ-038 Request at 8000_0008 outstanding, redirect to 8000_0100 with no data_ok -> ireq_addr stays 8000_0008 until data_ok, response not presented, next ireq_addr 8000_0100.
REQ-039 Redirect to 8000_0203 coincident with data_ok -> data discarded, instr_valid=0 next cycle, next ireq_addr 8000_0200.
REQ-040 Redirect in HOLD -> buffer and slot flushed, instr_valid=0, next request at target.
REQ-041 Reset asserted mid-request and mid-HOLD -> instr_valid=0, ireq_valid=0 during reset, fetch restarts at PCINIT.
